// File: rtl/nab_axi_pkg.sv
// rtl/nab_axi_pkg.sv - shared AXI4-Lite response codes, register index classes and helpers
package nab_axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } axi_resp_e;

  typedef enum logic [1:0] {
    IDX_RW,
    IDX_RO,
    IDX_UNMAPPED
  } idx_class_e;

  // Byte-offset bits below the word index: 2 for 32-bit, 3 for 64-bit registers.
  function automatic int addr_lsb(input int data_width);
    return (data_width == 64) ? 3 : 2;
  endfunction

  function automatic idx_class_e classify(input logic [31:0] idx, input int num_rw, input int num_ro);
    if (idx < 32'(num_rw))
      return IDX_RW;
    else if (idx < 32'(num_rw + num_ro))
      return IDX_RO;
    else
      return IDX_UNMAPPED;
  endfunction

endpackage

// File: rtl/axi_lite_reg_bank_rd_mux.sv
// rtl/axi_lite_reg_bank_rd_mux.sv - combinational read-data select over RW and RO registers
module axi_lite_reg_bank_rd_mux
  import nab_axi_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int NUM_RW_REGS = 8,
  parameter int NUM_RO_REGS = 4
) (
  input  logic [ADDR_WIDTH-addr_lsb(DATA_WIDTH)-1:0] rd_idx,
  input  logic [NUM_RW_REGS*DATA_WIDTH-1:0]          rw_regs,
  input  logic [NUM_RO_REGS*DATA_WIDTH-1:0]          ro_regs,
  output logic [DATA_WIDTH-1:0]                      rd_data
);

  // Unmapped indices fall through to the zero default.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RW_REGS; k++) begin
      if (32'(rd_idx) == 32'(k))
        rd_data = rw_regs[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int j = 0; j < NUM_RO_REGS; j++) begin
      if (32'(rd_idx) == 32'(NUM_RW_REGS + j))
        rd_data = ro_regs[j*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/axi_lite_reg_bank.sv
// rtl/axi_lite_reg_bank.sv - AXI4-Lite RW/RO register bank
// Define AXI_LITE_REG_BANK_SLVERR_EN to return SLVERR for RO/unmapped writes and unmapped reads.
module axi_lite_reg_bank
  import nab_axi_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 9,
  parameter int NUM_RW_REGS = 8,
  parameter int NUM_RO_REGS = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [ADDR_WIDTH-1:0]             S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]             S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]           S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]             S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]             S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [NUM_RW_REGS*DATA_WIDTH-1:0] rw_regs,
  output logic [NUM_RW_REGS-1:0]            rw_wr_pulse,
  input  logic [NUM_RO_REGS*DATA_WIDTH-1:0] ro_regs
);

  localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
  localparam int IDX_W    = ADDR_WIDTH - ADDR_LSB;
  localparam int STRB_W   = DATA_WIDTH / 8;

  logic [IDX_W-1:0]                  wr_idx;
  logic [IDX_W-1:0]                  rd_idx;
  logic                              wr_accept;
  logic                              rd_accept;
  logic                              bvalid_q;
  logic                              rvalid_q;
  logic [DATA_WIDTH-1:0]             rdata_q;
  logic [DATA_WIDTH-1:0]             rd_data_mux;
  logic [NUM_RW_REGS*DATA_WIDTH-1:0] rw_q;
  logic [NUM_RW_REGS-1:0]            pulse_q;
  logic                              unused_addr_bits;

  assign wr_idx           = S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign rd_idx           = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign unused_addr_bits = ^{S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

  // Ready is combinational so an accept is possible on the first edge after reset release;
  // gating with reset keeps the readies low while reset is held.
  assign wr_accept = S_AXI_ARESETN && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
  assign rd_accept = S_AXI_ARESETN && S_AXI_ARVALID && !rvalid_q;

  assign S_AXI_AWREADY = wr_accept;
  assign S_AXI_WREADY  = wr_accept;
  assign S_AXI_ARREADY = rd_accept;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign rw_regs       = rw_q;
  assign rw_wr_pulse   = pulse_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rw_q    <= '0;
      pulse_q <= '0;
    end else begin
      pulse_q <= '0;
      if (wr_accept) begin
        for (int k = 0; k < NUM_RW_REGS; k++) begin
          if (32'(wr_idx) == 32'(k)) begin
            pulse_q[k] <= 1'b1;
            for (int b = 0; b < STRB_W; b++) begin
              if (S_AXI_WSTRB[b])
                rw_q[k*DATA_WIDTH + b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bvalid_q <= 1'b0;
    end else if (wr_accept) begin
      bvalid_q <= 1'b1;
    end else if (S_AXI_BREADY) begin
      bvalid_q <= 1'b0;
    end
  end

  // The mux sees pre-write register contents, so a same-cycle read returns the old value.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else if (rd_accept) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data_mux;
    end else if (S_AXI_RREADY) begin
      rvalid_q <= 1'b0;
    end
  end

  axi_lite_reg_bank_rd_mux #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .NUM_RW_REGS (NUM_RW_REGS),
    .NUM_RO_REGS (NUM_RO_REGS)
  ) u_rd_mux (
    .rd_idx  (rd_idx),
    .rw_regs (rw_q),
    .ro_regs (ro_regs),
    .rd_data (rd_data_mux)
  );

`ifdef AXI_LITE_REG_BANK_SLVERR_EN
  logic [1:0] bresp_q;
  logic [1:0] rresp_q;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      bresp_q <= RESP_OKAY;
      rresp_q <= RESP_OKAY;
    end else begin
      if (wr_accept)
        bresp_q <= (classify(32'(wr_idx), NUM_RW_REGS, NUM_RO_REGS) == IDX_RW) ? RESP_OKAY : RESP_SLVERR;
      if (rd_accept)
        rresp_q <= (classify(32'(rd_idx), NUM_RW_REGS, NUM_RO_REGS) == IDX_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
    end
  end

  assign S_AXI_BRESP = bresp_q;
  assign S_AXI_RRESP = rresp_q;
`else
  assign S_AXI_BRESP = RESP_OKAY;
  assign S_AXI_RRESP = RESP_OKAY;
`endif

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// tb/tb_axi_lite_reg_bank.sv - self-checking bench for axi_lite_reg_bank
module tb_axi_lite_reg_bank;

  localparam int DW  = 32;
  localparam int AW  = 9;
  localparam int NRW = 8;
  localparam int NRO = 4;
`ifdef AXI_LITE_REG_BANK_SLVERR_EN
  localparam logic [1:0] SLV = 2'b10;
`else
  localparam logic [1:0] SLV = 2'b00;
`endif

  logic              clk;
  logic              rst_n;
  logic [AW-1:0]     awaddr;
  logic              awvalid;
  logic              awready;
  logic [DW-1:0]     wdata;
  logic [DW/8-1:0]   wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AW-1:0]     araddr;
  logic              arvalid;
  logic              arready;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [NRW*DW-1:0] rw_regs;
  logic [NRW-1:0]    rw_wr_pulse;
  logic [NRO*DW-1:0] ro_regs;

  axi_lite_reg_bank dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .rw_regs       (rw_regs),
    .rw_wr_pulse   (rw_wr_pulse),
    .ro_regs       (ro_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    int          idx;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [7:0]  exp_pulse;
  } vec_t;

  int          tests;
  int          fails;
  logic [31:0] mrw [NRW];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int k = 0; k < NRW; k++) f[k*32 +: 32] = mrw[k];
    return f;
  endfunction

  function automatic void model_write(input int idx, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    if (idx >= NRW) return;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    mrw[idx] = (mrw[idx] & ~m) | (d & m);
  endfunction

  function automatic logic [31:0] model_read(input int idx);
    if (idx < NRW) return mrw[idx];
    if (idx < NRW + NRO) return ro_regs[(idx - NRW)*32 +: 32];
    return 32'h0;
  endfunction

  task automatic xact(input bit do_wr, input bit do_rd, input int widx, input logic [31:0] wd,
                      input logic [3:0] ws, input int ridx, input int delay,
                      output logic [1:0] b_resp, output logic [31:0] r_data,
                      output logic [1:0] r_resp, output logic [7:0] pulse, output int waited);
    @(negedge clk);
    awaddr  = AW'(widx*4 + int'($urandom_range(0, 3)));
    araddr  = AW'(ridx*4 + int'($urandom_range(0, 3)));
    wdata   = wd;
    wstrb   = ws;
    awvalid = do_wr;
    wvalid  = do_wr;
    arvalid = do_rd;
    waited  = 0;
    b_resp  = 2'b11;
    r_data  = 32'hx;
    r_resp  = 2'b11;
    pulse   = 8'hx;
    #1;
    while (!((!do_wr || (awready && wready)) && (!do_rd || arready)) && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (waited >= 20) begin
      check("accept_timeout", 256'(waited), 256'(0));
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    pulse = rw_wr_pulse;
    check("bvalid_latency", 256'(bvalid), 256'(do_wr));
    check("rvalid_latency", 256'(rvalid), 256'(do_rd));
    repeat (delay) begin
      @(posedge clk);
      #1;
    end
    b_resp = bresp;
    r_data = rdata;
    r_resp = rresp;
    bready = 1'b1;
    rready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;
    rready = 1'b0;
    check("pulse_cleared", 256'(rw_wr_pulse), 256'(0));
    check("bvalid_cleared", 256'(bvalid), 256'(0));
    check("rvalid_cleared", 256'(rvalid), 256'(0));
  endtask

  vec_t        vecs[$];
  logic [1:0]  g_bresp;
  logic [1:0]  g_rresp;
  logic [31:0] g_rdata;
  logic [7:0]  g_pulse;
  int          g_wait;

  initial begin
    tests = 0;
    fails = 0;
    for (int i = 0; i < NRW; i++) vecs.push_back('{1'b1, i, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 8'(1 << i)});
    for (int i = 0; i < NRW; i++) vecs.push_back('{1'b0, i, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 8'h00});
    vecs.push_back('{1'b1, 2,  32'h00000000, 4'b0101, 32'h0,        2'b00, 8'h04});
    vecs.push_back('{1'b0, 2,  32'h0,        4'h0,    32'hDE00BE00, 2'b00, 8'h00});
    vecs.push_back('{1'b0, 8,  32'h0,        4'h0,    32'h12345678, 2'b00, 8'h00});
    vecs.push_back('{1'b1, 8,  32'hFFFFFFFF, 4'hF,    32'h0,        SLV,   8'h00});
    vecs.push_back('{1'b0, 8,  32'h0,        4'h0,    32'h12345678, 2'b00, 8'h00});
    vecs.push_back('{1'b0, 0,  32'h0,        4'h0,    32'hDEADBEEF, 2'b00, 8'h00});
    vecs.push_back('{1'b0, 20, 32'h0,        4'h0,    32'h00000000, SLV,   8'h00});
    vecs.push_back('{1'b1, 1,  32'h00000000, 4'h0,    32'h0,        2'b00, 8'h02});
    vecs.push_back('{1'b0, 1,  32'h0,        4'h0,    32'hDEADBEEF, 2'b00, 8'h00});
    vecs.push_back('{1'b1, 20, 32'h00001234, 4'hF,    32'h0,        SLV,   8'h00});
    vecs.push_back('{1'b0, 2,  32'h0,        4'h0,    32'hDE00BE00, 2'b00, 8'h00});

    for (int k = 0; k < NRW; k++) mrw[k] = 32'h0;
    rst_n = 1'b0;
    awaddr = '0; araddr = '0; wdata = 32'h11111111; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    ro_regs = '0;

    // Reset: outputs low even with requests pending.
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 256'(awready), 256'(0));
    check("rst_wready", 256'(wready), 256'(0));
    check("rst_arready", 256'(arready), 256'(0));
    check("rst_bvalid", 256'(bvalid), 256'(0));
    check("rst_rvalid", 256'(rvalid), 256'(0));
    check("rst_rdata", 256'(rdata), 256'(0));
    check("rst_bresp", 256'(bresp), 256'(0));
    check("rst_rresp", 256'(rresp), 256'(0));
    check("rst_rw_regs", 256'(rw_regs), 256'(0));
    check("rst_pulse", 256'(rw_wr_pulse), 256'(0));

    // First accept on the first edge after release.
    @(negedge clk);
    arvalid = 1'b0; bready = 1'b0; rready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(0, 32'h11111111, 4'hF);
    check("first_accept_bvalid", 256'(bvalid), 256'(1));
    check("first_accept_pulse", 256'(rw_wr_pulse), 256'(1));
    check("first_accept_regs", 256'(rw_regs), model_flat());
    bready = 1'b1;
    @(posedge clk);
    #1;
    bready = 1'b0;

    ro_regs = 128'h0000000C_0000000B_0000000A_12345678;
    foreach (vecs[i]) begin
      xact(vecs[i].wr, !vecs[i].wr, vecs[i].idx, vecs[i].data, vecs[i].strb, vecs[i].idx,
           int'($urandom_range(0, 2)), g_bresp, g_rdata, g_rresp, g_pulse, g_wait);
      if (vecs[i].wr) begin
        model_write(vecs[i].idx, vecs[i].data, vecs[i].strb);
        check($sformatf("vec%0d_bresp", i), 256'(g_bresp), 256'(vecs[i].exp_resp));
        check($sformatf("vec%0d_pulse", i), 256'(g_pulse), 256'(vecs[i].exp_pulse));
      end else begin
        check($sformatf("vec%0d_rdata", i), 256'(g_rdata), 256'(vecs[i].exp_rdata));
        check($sformatf("vec%0d_rresp", i), 256'(g_rresp), 256'(vecs[i].exp_resp));
      end
      check($sformatf("vec%0d_regs", i), 256'(rw_regs), model_flat());
    end

    // Same-cycle write and read of one register: read sees the old value.
    xact(1'b1, 1'b0, 3, 32'h5, 4'hF, 0, 0, g_bresp, g_rdata, g_rresp, g_pulse, g_wait);
    model_write(3, 32'h5, 4'hF);
    xact(1'b1, 1'b1, 3, 32'h1, 4'hF, 3, 0, g_bresp, g_rdata, g_rresp, g_pulse, g_wait);
    model_write(3, 32'h1, 4'hF);
    check("collide_wait", 256'(g_wait), 256'(0));
    check("collide_old_value", 256'(g_rdata), 256'(32'h5));
    check("collide_pulse", 256'(g_pulse), 256'(8'h08));
    xact(1'b0, 1'b1, 0, 32'h0, 4'h0, 3, 0, g_bresp, g_rdata, g_rresp, g_pulse, g_wait);
    check("collide_new_value", 256'(g_rdata), 256'(32'h1));

    // Randomized traffic against the model.
    for (int n = 0; n < 150; n++) begin
      bit          dw;
      bit          dr;
      int          wi;
      int          ri;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] exp_r;
      dw = 1'($urandom_range(0, 1));
      dr = dw ? 1'($urandom_range(0, 1)) : 1'b1;
      wi = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 127)) : int'($urandom_range(0, 11));
      ri = ($urandom_range(0, 9) == 0) ? int'($urandom_range(12, 127)) : int'($urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) ri = wi;
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      ro_regs = {$urandom, $urandom, $urandom, $urandom};
      exp_r = model_read(ri);
      xact(dw, dr, wi, d, s, ri, int'($urandom_range(0, 3)), g_bresp, g_rdata, g_rresp, g_pulse, g_wait);
      if (dw) begin
        model_write(wi, d, s);
        check("rnd_bresp", 256'(g_bresp), 256'((wi < NRW) ? 2'b00 : SLV));
        check("rnd_pulse", 256'(g_pulse), 256'((wi < NRW) ? 8'(1 << wi) : 8'h00));
      end else begin
        check("rnd_no_pulse", 256'(g_pulse), 256'(0));
      end
      if (dr) begin
        check("rnd_rdata", 256'(g_rdata), 256'(exp_r));
        check("rnd_rresp", 256'(g_rresp), 256'((ri < NRW + NRO) ? 2'b00 : SLV));
      end
      check("rnd_regs", 256'(rw_regs), model_flat());
    end

    // Stalled responses, pending new requests, then reset mid-hold.
    ro_regs = 128'h0000000C_0000000B_CAFE0001_12345678;
    @(negedge clk);
    awaddr = AW'(5*4); wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = AW'(9*4); arvalid = 1'b1;
    @(posedge clk);
    #1;
    model_write(5, 32'hCAFEF00D, 4'hF);
    awaddr = AW'(6*4); wdata = 32'h0BAD0BAD; araddr = AW'(0);
    ro_regs = 128'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("hold_bvalid", 256'(bvalid), 256'(1));
      check("hold_rvalid", 256'(rvalid), 256'(1));
      check("hold_rdata", 256'(rdata), 256'(32'hCAFE0001));
      check("hold_no_accept", 256'({awready, wready, arready}), 256'(0));
      check("hold_regs", 256'(rw_regs), model_flat());
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 256'({bvalid, rvalid, awready, wready, arready, bresp, rresp}), 256'(0));
    check("async_rst_rdata", 256'(rdata), 256'(0));
    check("async_rst_regs", 256'(rw_regs), 256'(0));
    @(posedge clk);
    #1;
    check("rst_edge_outputs", 256'({bvalid, rvalid, awready, wready, arready, rw_wr_pulse}), 256'(0));
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NRW; k++) mrw[k] = 32'h0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("no_resp_after_abort", 256'({bvalid, rvalid}), 256'(0));
    end
    check("regs_after_abort", 256'(rw_regs), model_flat());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
